stall_pipe_chain: RTL

STALL_PIPE_CHAIN -- requirements
Module: stall_pipe_chain

---
 rtl/stall_pipe_chain.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stall_pipe_chain.sv
// Purpose: DEPTH-stage payload pipeline with per-stage stall/flush, bubble collapse and a saturating drop counter.
// Latency: DEPTH cycles from input accept to output when nothing holds; count/stage_valid follow the registered state.
// Backpressure: out_ready_i low or stall_i holds propagate upstream through valid stages only; in_ready_o = ~hold[0].
module stall_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         in_ready_o,
  input  logic [DEPTH-1:0]             stall_i,
  input  logic [DEPTH-1:0]             flush_i,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         out_ready_i,
  output logic [DEPTH-1:0]             stage_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);

  localparam int CW = $clog2(DEPTH+1);
  // Sum width wide enough for counter plus a full-pipe kill, so saturation is detected before truncation.
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            hold;
  logic [DEPTH-1:0]            wr_valid;
  logic [CW-1:0]               kill_sum;
  logic [CW-1:0]               vcount;
  logic [SW-1:0]               drop_sum;
  logic [CNT_W-1:0]            drop_q, drop_d;

  // Hold chain: a stage holds when stalled, or when it is occupied and the stage below cannot take it.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall_i[DEPTH-1] | (valid_q[DEPTH-1] & ~out_ready_i);
    for (int k = DEPTH-2; k >= 0; k--) begin
      hold[k] = stall_i[k] | (valid_q[k] & hold[k+1]);
    end
  end

  // Next-state per stage; wr_valid is the valid bit that would land absent flush (used to count kills).
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    wr_valid = '0;
    kill_sum = '0;

    if (hold[0]) begin
      wr_valid[0] = valid_q[0];
    end else begin
      wr_valid[0] = in_valid_i;
      valid_d[0]  = in_valid_i;
      data_d[0]   = in_valid_i ? in_data_i : '0;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (hold[k]) begin
        wr_valid[k] = valid_q[k];
      end else if (!hold[k-1]) begin
        wr_valid[k] = valid_q[k-1];
        valid_d[k]  = valid_q[k-1];
        data_d[k]   = data_q[k-1];
      end else begin
        valid_d[k]  = 1'b0;
        data_d[k]   = '0;
      end
    end

    // Flush kills whatever would be written into the stage; the payload leaving it has already moved on.
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
        kill_sum   = kill_sum + CW'(wr_valid[k]);
      end
    end
  end

  // Saturating accumulation of killed payloads.
  always_comb begin
    drop_sum = SW'(drop_q) + SW'(kill_sum);
    if (drop_sum > SW'({CNT_W{1'b1}})) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[CNT_W-1:0];
    end
  end

  // Stage registers and drop counter; reset wins over stall and flush and never counts as a drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  // Occupancy from registered valid bits.
  always_comb begin
    vcount = '0;
    for (int k = 0; k < DEPTH; k++) begin
      vcount = vcount + CW'(valid_q[k]);
    end
  end

  assign in_ready_o    = ~hold[0];
  assign out_valid_o   = valid_q[DEPTH-1] & ~stall_i[DEPTH-1];
  assign out_data_o    = data_q[DEPTH-1];
  assign stage_valid_o = valid_q;
  assign count_o       = vcount;
  assign drop_cnt_o    = drop_q;

endmodule
